// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC sequencer and single-outstanding instruction fetch stage with
//            instruction register. Optional MISALIGN_TRAP_EN adds epc/trap.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] RD1,
    input  logic        retire,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPLUS4,
`ifdef MISALIGN_TRAP_EN
    output logic [31:0] epc,
    output logic        trap,
`endif
    output logic [31:0] instret
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [31:0] r_instret;
    // Keeps the request strobe low while reset is held; the first request
    // goes out on the cycle after reset release.
    logic        r_req_en;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;
    logic        w_retire;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_retire   = (r_state == S_EXEC) && retire && !stall;

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (NPCOp)
            2'b00:   w_next_pc = w_pc_plus4;
            2'b01:   w_next_pc = w_pc_plus4 + w_br_off;
            2'b10:   w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
            default: w_next_pc = RD1;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic [31:0] r_epc;
    logic        r_trap;
    logic        w_misaligned;

    assign w_misaligned = (w_next_pc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_epc  <= 32'h0;
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_retire && w_misaligned;
            if (w_retire && w_misaligned)
                r_epc <= w_next_pc;
        end
    end

    assign epc  = r_epc;
    assign trap = r_trap;
`else
    logic w_unused_trap;
    assign w_unused_trap = ^{TRAP_VEC, w_next_pc[1:0]};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_instret     <= 32'h0;
            r_req_en      <= 1'b0;
        end else begin
            r_req_en <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (r_req_en)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_retire) begin
`ifdef MISALIGN_TRAP_EN
                        r_pc <= w_misaligned ? TRAP_VEC : w_next_pc;
`else
                        r_pc <= {w_next_pc[31:2], 2'b00};
`endif
                        r_instret     <= r_instret + 32'd1;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_req    = (r_state == S_FETCH) && r_req_en;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign PC          = r_pc;
    assign PCPLUS4     = w_pc_plus4;
    assign instret     = r_instret;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage that sits directly upstream of the instruction decoder.
- Holds the architectural PC, issues one request at a time to a variable-latency instruction memory, and latches the returned word into an instruction register.
- Presents Op/Funct/fields to the decoder. Consumes the decoder's NPCOp to pick the next PC when the current instruction retires.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0080, redirect target for misaligned fetch (used only with MISALIGN_TRAP_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- NPCOp  in  2  next-PC select from decoder: 00 PC+4, 01 branch, 10 jump, 11 register (jr/jalr).
- RD1  in  32  rs register value, the target for NPCOp=11.
- retire  in  1  datapath commit pulse for the instruction held in IR.
- stall  in  1  hold request; blocks retirement while high.
- imem_req  out  1  one-cycle request strobe.
- imem_addr  out  32  word address of the request (equals PC).
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- instr  out  32  instruction register; Op=instr[31:26], Funct=instr[5:0].
- instr_valid  out  1  IR holds a fetched, unretired instruction.
- PC  out  32  current PC.
- PCPLUS4  out  32  PC+4, used for the jal/jalr link write.
- instret  out  32  retired-instruction counter.

Behaviour:
- Reset (rstn low, asynchronous):
  - PC=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, instret=0, state=S_FETCH.
  - The optional outputs go to 0.
  - Reset mid-request abandons the request. The instruction memory shares rstn and must not deliver stale data.
- FSM, one outstanding request maximum:
  - S_FETCH: imem_req=1, imem_addr=PC for exactly one cycle; next state S_WAIT.
  - S_WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_valid<=1, next state S_EXEC. Otherwise stay; there is no timeout.
  - S_EXEC: instr_valid=1, decoder operates on instr.
    - If retire=1 and stall=0: PC<=next_pc, instret<=instret+1, instr_valid<=0, next state S_FETCH.
    - If stall=1: hold everything; retire is ignored.
- imem_rvalid is ignored in S_FETCH and S_EXEC. Memory latency is at least 1 cycle.
- Minimum throughput: 3 cycles per instruction (FETCH, WAIT with same-cycle rvalid, EXEC with retire).
- next_pc, combinational from the registered PC:
  - 00: PC+4.
  - 01: PC+4 + ({{14{instr[15]}},instr[15:0],2'b00}).
  - 10: {PCPLUS4[31:28], instr[25:0], 2'b00}.
  - 11: RD1.
- Arithmetic and wrap rules:
  - All arithmetic is 32-bit modulo; PC 32'hFFFF_FFFC + 4 wraps to 0.
  - Branch offsets wrap likewise.
  - instret wraps 32'hFFFF_FFFF to 0.
- Branch condition: resolved by the decoder (NPCOp already gated by Zero). The fetch unit does not inspect Zero.
- No branch delay slot; the next fetch is always next_pc.
- retire outside S_EXEC is ignored. PC and instret change only on a qualified retire.
- PCPLUS4 is always PC+4 of the registered PC.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - On a qualified retire where next_pc[1:0]!=2'b00 (reachable only via NPCOp=11), PC<=TRAP_VEC.
  - Extra output epc (32) <= the misaligned next_pc.
  - Extra output trap (1) pulses high for one cycle in the following S_FETCH.
  - instret still increments.
- Not defined: next_pc[1:0] is forced to 2'b00 before loading PC; no epc/trap ports.

Test Plan:
1. Reset then sequential fetch: rstn low 2 cycles, release; memory returns 1-cycle latency, retire each S_EXEC with NPCOp=00 → imem_addr 0x0, 0x4, 0x8 on successive requests, every 3 cycles; instret=3 after third retire.
2. Branch: instr=0x1000FFFE at PC=0x100, NPCOp=01 → next imem_addr=0xFC. Same with instr[15:0]=0x7FFF at PC=0xFFFF_FFF0 → wraps to 0x0001_FFF0.
3. Jump/jr: instr=0x08000040 at PC=0x1000_0000 with NPCOp=10 → 0x1000_0100. NPCOp=11 with RD1=0x0000_2000 → 0x2000.
4. Handshake and stall:
   - rvalid delayed 5 cycles → instr_valid stays 0 and imem_req does not repeat.
   - stall=1 together with retire=1 for 4 cycles → PC/instret unchanged, then advance on the first cycle with stall=0 and retire=1.
   - Spurious rvalid in S_EXEC → instr unchanged.
5. Reset mid-operation: assert rstn low during S_WAIT → PC=RESET_PC, instr_valid=0, instret=0 immediately (asynchronous); after release, the first imem_req is at RESET_PC.
6. MISALIGN_TRAP_EN: NPCOp=11, RD1=0x0000_2002 → defined: PC=0x80, epc=0x2002, one trap pulse; undefined: PC=0x2000.
